// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - line-fill memory responder with programmable latency and word-writable store
module mem_line_responder #(
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req,
  input  logic [31:0]  mem_addr,
  output logic [127:0] mem_data,
  output logic         mem_ready,
  output logic         mem_err,
  output logic         busy,
  input  logic         init_we,
  input  logic [31:0]  init_addr,
  input  logic [31:0]  init_data
);

  localparam int LINE_AW = $clog2(MEM_LINES);
  localparam int WORD_AW = LINE_AW + 2;
  localparam int WORDS   = MEM_LINES * 4;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [27:0] line_q, line_d;

  // Backing store, one 32-bit entry per word; never cleared by reset
  logic [31:0] store_q [WORDS];

  // Preload port decode: anything above the store's byte range is dropped
  logic               wr_in_range;
  logic [WORD_AW-1:0] wr_idx;

  assign wr_in_range = (init_addr[31:WORD_AW+2] == '0);
  assign wr_idx      = init_addr[WORD_AW+1:2];

  // Read-side decode of the latched line index
  logic               rd_in_range;
  logic [LINE_AW-1:0] rd_idx;
  logic [127:0]       rd_line;

  assign rd_in_range = (line_q[27:LINE_AW] == '0);
  assign rd_idx      = line_q[LINE_AW-1:0];
  assign rd_line     = {store_q[{rd_idx, 2'd3}],
                        store_q[{rd_idx, 2'd2}],
                        store_q[{rd_idx, 2'd1}],
                        store_q[{rd_idx, 2'd0}]};

  // Byte-offset bits are don't-care on both address ports
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[3:0], init_addr[1:0]};

  // Preload writes commit on any edge, independent of the FSM
  always_ff @(posedge clk) begin
    if (init_we && wr_in_range) begin
      store_q[wr_idx] <= init_data;
    end
  end

  // State, latency counter and latched line index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, wait for request drop in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          line_d  = mem_addr[31:4];
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = DONE;
      end
      DONE: begin
        if (!mem_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from the state register only, so reset clears them at once
  always_comb begin
    mem_data  = '0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == RESP) begin
      mem_ready = 1'b1;
      if (rd_in_range) begin
        mem_data = rd_line;
      end else begin
        mem_err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - scoreboard bench for mem_line_responder
module tb_mem_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req4 = 1'b0, req1 = 1'b0;
  logic [31:0]  addr4 = '0, addr1 = '0;
  logic [127:0] data4, data1;
  logic         rdy4, rdy1, err4, err1, busy4, busy1;
  logic         init_we = 1'b0;
  logic [31:0]  init_addr = '0, init_data = '0;

  always #5 clk = ~clk;

  mem_line_responder #(.MEM_LINES(1024), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .mem_req(req4), .mem_addr(addr4),
    .mem_data(data4), .mem_ready(rdy4), .mem_err(err4), .busy(busy4),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  mem_line_responder #(.MEM_LINES(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(addr1),
    .mem_data(data1), .mem_ready(rdy1), .mem_err(err1), .busy(busy1),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  longint      acc_time;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    int li;
    l  = '0;
    li = int'(a[31:4]);
    if (li >= 1024) return '0;
    for (int w = 0; w < 4; w++) begin
      if (model.exists(li * 4 + w)) l[w*32 +: 32] = model[li * 4 + w];
    end
    return l;
  endfunction

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.data = model_line(a);
    e.err  = (a[31:4] >= 28'd1024);
    sb.push_back(e);
  endtask

  // Called at a negedge; ends at the following negedge
  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    init_we = 1'b1;
    init_addr = a;
    init_data = d;
    @(posedge clk);
    if (a[31:14] == '0) model[int'(a[31:2])] = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; ends at the negedge after acceptance
  task automatic start_req(input bit sel, input logic [31:0] a);
    if (sel) begin req1 = 1'b1; addr1 = a; end
    else     begin req4 = 1'b1; addr4 = a; end
    @(posedge clk);
    acc_time = longint'($time);
    @(negedge clk);
    if (sel) addr1 = 32'hFFFF_FFF0; else addr4 = 32'hFFFF_FFF0;
  endtask

  // Waits (bounded) for the ready pulse, then scores latency, data and error flag
  task automatic wait_ready(input bit sel, input int exp_lat, input string tag);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while (!(sel ? rdy1 : rdy4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = (n >= 20) ? -1 : int'((longint'($time) - acc_time + 5) / 10);
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.data = 'x; e.err = 1'bx; end
    chk({tag, "_data"}, sel ? data1 : data4, e.data);
    chk({tag, "_err"}, 128'(sel ? err1 : err4), 128'(e.err));
  endtask

  task automatic end_req(input bit sel, input string tag);
    if (sel) req1 = 1'b0; else req4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, 128'(sel ? busy1 : busy4), 128'(0));
  endtask

  initial begin
    int cnt;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(rdy4), 128'(0));
    chk("rst_busy", 128'(busy4), 128'(0));
    chk("rst_err", 128'(err4), 128'(0));
    chk("rst_data", data4, 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Preload lines 0x000, 0x100, 0x200 and the last in-range line
    for (int w = 0; w < 4; w++) wr_word(32'h0000 + 32'(w * 4), 32'h1000_0000 + 32'(w));
    for (int w = 0; w < 4; w++) wr_word(32'h0100 + 32'(w * 4), 32'hA0 + 32'(w));
    for (int w = 0; w < 4; w++) wr_word(32'h0200 + 32'(w * 4), 32'h2000_0000 + 32'(w));
    for (int w = 0; w < 4; w++) wr_word(32'h3FF0 + 32'(w * 4), 32'hC0DE_0000 + 32'(w));

    // Word ordering; low address bits ignored
    push_exp(32'h10C);
    start_req(1'b0, 32'h10C);
    wait_ready(1'b0, 4, "order");
    chk("order_const", data4, 128'h000000A3_000000A2_000000A1_000000A0);
    @(negedge clk);
    chk("order_pulse", 128'(rdy4), 128'(0));
    chk("order_done_busy", 128'(busy4), 128'(1));
    end_req(1'b0, "order");

    // Reset in the middle of WAIT abandons the request
    start_req(1'b0, 32'h100);
    @(negedge clk);
    chk("wait_busy", 128'(busy4), 128'(1));
    #2 rst = 1'b0;
    req4 = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy4), 128'(0));
    chk("midrst_ready", 128'(rdy4), 128'(0));
    chk("midrst_err", 128'(err4), 128'(0));
    chk("midrst_data", data4, 128'(0));
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy4) cnt++;
    end
    chk("abandoned_no_ready", 128'(cnt), 128'(0));
    push_exp(32'h100);
    start_req(1'b0, 32'h100);
    wait_ready(1'b0, 4, "post_rst");
    @(negedge clk);
    end_req(1'b0, "post_rst");

    // Latency 1 instance
    push_exp(32'h0);
    start_req(1'b1, 32'h0);
    wait_ready(1'b1, 1, "lat1");
    chk("lat1_resp_busy", 128'(busy1), 128'(1));
    @(negedge clk);
    chk("lat1_pulse", 128'(rdy1), 128'(0));
    chk("lat1_done_busy", 128'(busy1), 128'(1));
    end_req(1'b1, "lat1");

    // Held request yields one pulse; one low cycle permits the next request
    push_exp(32'h0);
    start_req(1'b0, 32'h0);
    wait_ready(1'b0, 4, "held1");
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy4) cnt++;
    end
    chk("held_no_repeat", 128'(cnt), 128'(0));
    req4 = 1'b0;
    @(negedge clk);
    push_exp(32'h204);
    start_req(1'b0, 32'h204);
    wait_ready(1'b0, 4, "held2");
    @(negedge clk);
    end_req(1'b0, "held2");

    // Out-of-range line index, then an out-of-range preload
    push_exp(32'h4000);
    start_req(1'b0, 32'h4000);
    wait_ready(1'b0, 4, "oor");
    chk("oor_err_const", 128'(err4), 128'(1));
    @(negedge clk);
    chk("oor_err_pulse", 128'(err4), 128'(0));
    end_req(1'b0, "oor");
    wr_word(32'h4000, 32'hDEAD_BEEF);
    push_exp(32'h0);
    start_req(1'b0, 32'h0);
    wait_ready(1'b0, 4, "oor_line0");
    @(negedge clk);
    end_req(1'b0, "oor_line0");
    push_exp(32'h3FF0);
    start_req(1'b0, 32'h3FF0);
    wait_ready(1'b0, 4, "last_line");
    @(negedge clk);
    end_req(1'b0, "last_line");

    // Write during WAIT is visible; write during RESP shows up next time
    start_req(1'b0, 32'h200);
    wr_word(32'h200, 32'h55);
    push_exp(32'h200);
    wait_ready(1'b0, 4, "wwait");
    chk("wwait_word0", 128'(data4[31:0]), 128'(32'h55));
    wr_word(32'h200, 32'h66);
    end_req(1'b0, "wresp");
    push_exp(32'h200);
    start_req(1'b0, 32'h200);
    wait_ready(1'b0, 4, "wresp_next");
    chk("wresp_word0", 128'(data4[31:0]), 128'(32'h66));
    @(negedge clk);
    end_req(1'b0, "wresp_next");

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
